// File: rtl/uart_phy_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_phy_if
//  Description : Signal bundle between the bus-side serial port slave and the
//                UART serial-line PHY.
//                  tx_start  : level request to send tx_dat when TX is idle
//                  tx_dat    : byte to transmit, sampled on acceptance
//                  tx_busy   : TX frame in progress
//                  txd       : serial TX line, idle high
//                  rxd       : serial RX line (asynchronous to clk_bus)
//                  rx_ready  : 1-cycle pulse, rx_dat holds a new byte
//                  rx_dat    : last good received byte
//                  rx_err    : 1-cycle pulse, framing / parity error
//                slave  = the PHY itself
//                master = everything around it (bus slave + line driver)
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_phy_if;
    logic       tx_start;
    logic [7:0] tx_dat;
    logic       tx_busy;
    logic       txd;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_dat;
    logic       rx_err;

    modport master (
        output tx_start, tx_dat, rxd,
        input  tx_busy, txd, rx_ready, rx_dat, rx_err
    );

    modport slave (
        input  tx_start, tx_dat, rxd,
        output tx_busy, txd, rx_ready, rx_dat, rx_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_phy.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_phy
//  Description : Serial-line end of the UART byte interface. Single clock
//                domain (clk_bus), synchronous active-high reset (rst_bus).
//                TX serialises bytes accepted on tx_start, LSB first.
//                RX synchronises rxd, samples each bit at its centre and
//                reports bytes with rx_ready or bad frames with rx_err.
//                Default framing 8N1 (10 bit times).
//                Build option UART_PARITY_EN: 8E1 framing (11 bit times),
//                even parity = XOR of the data bits, inserted after bit 7.
//  Ports       : clk_bus, rst_bus           clock / reset
//                phy (uart_phy_if.slave)    tx_start, tx_dat, tx_busy, txd,
//                                           rxd, rx_ready, rx_dat, rx_err
//  Parameters  : CLK_DIV  clk_bus cycles per bit (>= 4)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_phy #(
    parameter int CLK_DIV = 434
) (
    input  wire logic   clk_bus,
    input  wire logic   rst_bus,
    uart_phy_if.slave   phy
);

    localparam int              c_CW       = $clog2(CLK_DIV);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLK_DIV - 1);
    // Start bit is re-checked half a bit after the falling edge, which puts
    // every following sample at a bit centre.
    localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(CLK_DIV / 2 - 1);

    // ------------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    tx_state_t         r_tx_state, w_tx_state_nx;
    logic [c_CW-1:0]   r_tx_cnt,   w_tx_cnt_nx;
    logic [2:0]        r_tx_bit,   w_tx_bit_nx;
    logic [7:0]        r_tx_shift, w_tx_shift_nx;
    logic              r_txd,      w_txd_nx;
    logic              r_tx_busy,  w_tx_busy_nx;
    logic              w_tx_last;
`ifdef UART_PARITY_EN
    logic              r_tx_par,   w_tx_par_nx;
`endif

    assign w_tx_last = (r_tx_cnt == c_CNT_LAST);

    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_nx = r_tx_shift;
`ifdef UART_PARITY_EN
        w_tx_par_nx   = r_tx_par;
`endif
        case (r_tx_state)
            TX_IDLE: begin
                if (phy.tx_start) begin
                    w_tx_state_nx = TX_START;
                    w_tx_cnt_nx   = '0;
                    w_tx_shift_nx = phy.tx_dat;
`ifdef UART_PARITY_EN
                    w_tx_par_nx   = ^phy.tx_dat;
`endif
                end
            end
            TX_START: begin
                if (w_tx_last) begin
                    w_tx_state_nx = TX_DATA;
                    w_tx_cnt_nx   = '0;
                    w_tx_bit_nx   = 3'd0;
                end else begin
                    w_tx_cnt_nx   = r_tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (w_tx_last) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_tx_state_nx = TX_PARITY;
`else
                        w_tx_state_nx = TX_STOP;
`endif
                    end else begin
                        w_tx_bit_nx   = r_tx_bit + 1'b1;
                    end
                end else begin
                    w_tx_cnt_nx   = r_tx_cnt + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (w_tx_last) begin
                    w_tx_state_nx = TX_STOP;
                    w_tx_cnt_nx   = '0;
                end else begin
                    w_tx_cnt_nx   = r_tx_cnt + 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (w_tx_last) begin
                    w_tx_state_nx = TX_IDLE;
                    w_tx_cnt_nx   = '0;
                end else begin
                    w_tx_cnt_nx   = r_tx_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_state_nx = TX_IDLE;
                w_tx_cnt_nx   = '0;
            end
        endcase

        // txd and tx_busy are registered from the next-state values so the
        // line never glitches at bit boundaries.
        case (w_tx_state_nx)
            TX_START:  w_txd_nx = 1'b0;
            TX_DATA:   w_txd_nx = w_tx_shift_nx[0];
`ifdef UART_PARITY_EN
            TX_PARITY: w_txd_nx = w_tx_par_nx;
`endif
            default:   w_txd_nx = 1'b1;
        endcase
        w_tx_busy_nx = (w_tx_state_nx != TX_IDLE);
    end

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_txd      <= 1'b1;
            r_tx_busy  <= 1'b0;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_txd      <= w_txd_nx;
            r_tx_busy  <= w_tx_busy_nx;
`ifdef UART_PARITY_EN
            r_tx_par   <= w_tx_par_nx;
`endif
        end
    end

    assign phy.txd     = r_txd;
    assign phy.tx_busy = r_tx_busy;

    // ------------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    // Synchroniser resets to the idle line level so reset release cannot
    // fake a start bit.
    logic              r_rxd_meta, r_rxd_sync;
    rx_state_t         r_rx_state, w_rx_state_nx;
    logic [c_CW-1:0]   r_rx_cnt,   w_rx_cnt_nx;
    logic [2:0]        r_rx_bit,   w_rx_bit_nx;
    logic [7:0]        r_rx_shift, w_rx_shift_nx;
    logic [7:0]        r_rx_dat,   w_rx_dat_nx;
    logic              r_rx_ready, w_rx_ready_nx;
    logic              r_rx_err,   w_rx_err_nx;
    logic              w_rx_last;
`ifdef UART_PARITY_EN
    logic              r_rx_par_bad, w_rx_par_bad_nx;
`endif

    assign w_rx_last = (r_rx_cnt == c_CNT_LAST);

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt;
        w_rx_bit_nx   = r_rx_bit;
        w_rx_shift_nx = r_rx_shift;
        w_rx_dat_nx   = r_rx_dat;
        w_rx_ready_nx = 1'b0;
        w_rx_err_nx   = 1'b0;
`ifdef UART_PARITY_EN
        w_rx_par_bad_nx = r_rx_par_bad;
`endif
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rxd_sync) begin
                    w_rx_state_nx = RX_START;
                    w_rx_cnt_nx   = '0;
                end
            end
            RX_START: begin
                if (r_rx_cnt == c_CNT_HALF) begin
                    w_rx_cnt_nx = '0;
                    w_rx_bit_nx = 3'd0;
                    // Line back high at mid start bit: glitch, drop silently.
                    w_rx_state_nx = r_rxd_sync ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (w_rx_last) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_shift_nx = {r_rxd_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_rx_state_nx = RX_PARITY;
`else
                        w_rx_state_nx = RX_STOP;
`endif
                    end else begin
                        w_rx_bit_nx   = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_nx   = r_rx_cnt + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (w_rx_last) begin
                    w_rx_cnt_nx     = '0;
                    w_rx_par_bad_nx = r_rxd_sync ^ (^r_rx_shift);
                    w_rx_state_nx   = RX_STOP;
                end else begin
                    w_rx_cnt_nx     = r_rx_cnt + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (w_rx_last) begin
                    w_rx_cnt_nx = '0;
                    if (r_rxd_sync) begin
                        w_rx_state_nx = RX_IDLE;
`ifdef UART_PARITY_EN
                        if (r_rx_par_bad) begin
                            w_rx_err_nx   = 1'b1;
                        end else begin
                            w_rx_ready_nx = 1'b1;
                            w_rx_dat_nx   = r_rx_shift;
                        end
`else
                        w_rx_ready_nx = 1'b1;
                        w_rx_dat_nx   = r_rx_shift;
`endif
                    end else begin
                        // Framing error; a held-low line must not retrigger.
                        w_rx_err_nx   = 1'b1;
                        w_rx_state_nx = RX_BREAK;
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_BREAK: begin
                if (r_rxd_sync) begin
                    w_rx_state_nx = RX_IDLE;
                end
            end
            default: begin
                w_rx_state_nx = RX_IDLE;
                w_rx_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_dat   <= 8'h00;
            r_rx_ready <= 1'b0;
            r_rx_err   <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_bad <= 1'b0;
`endif
        end else begin
            r_rxd_meta <= phy.rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_bit   <= w_rx_bit_nx;
            r_rx_shift <= w_rx_shift_nx;
            r_rx_dat   <= w_rx_dat_nx;
            r_rx_ready <= w_rx_ready_nx;
            r_rx_err   <= w_rx_err_nx;
`ifdef UART_PARITY_EN
            r_rx_par_bad <= w_rx_par_bad_nx;
`endif
        end
    end

    assign phy.rx_ready = r_rx_ready;
    assign phy.rx_err   = r_rx_err;
    assign phy.rx_dat   = r_rx_dat;

endmodule
`default_nettype wire

// File: tb/tb_uart_phy.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_phy
//  Description : Directed self-checking bench for uart_phy at CLK_DIV = 8.
//                Covers reset state, TX framing and timing, back-to-back TX
//                with held tx_start, TX reset abort, RX good frame, start-bit
//                glitch, framing error with held-low line, and (when
//                UART_PARITY_EN is defined) parity on TX and RX.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_phy;

    localparam int DIV = 8;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk_bus = 1'b0;
    logic rst_bus = 1'b1;

    uart_phy_if u_if ();

    uart_phy #(.CLK_DIV(DIV)) u_dut (
        .clk_bus (clk_bus),
        .rst_bus (rst_bus),
        .phy     (u_if.slave)
    );

    always #5 clk_bus = ~clk_bus;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // Pulse observers, sampled mid-cycle.
    int rdy_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    always @(negedge clk_bus) begin
        if (u_if.rx_ready === 1'b1) rdy_cnt++;
        if (u_if.rx_err === 1'b1) err_cnt++;
        if (u_if.rx_ready === 1'b1 && u_if.rx_err === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit idx of a serial frame: start, d[0..7], [parity], stop.
    function automatic logic frame_bit(input logic [7:0] d, input logic par,
                                       input logic stp, input int idx);
        logic r;
        if (idx == 0)      r = 1'b0;
        else if (idx <= 8) r = d[idx-1];
`ifdef UART_PARITY_EN
        else if (idx == 9) r = par;
`endif
        else               r = stp;
        return r;
    endfunction

    // Check {tx_busy, txd} for n cycles of a frame carrying d; called on the
    // first negedge after acceptance. Optionally changes tx_dat at cycle chg.
    task automatic check_tx(input string tag, input logic [7:0] d, input int n,
                            input int chg, input logic [7:0] new_dat);
        for (int i = 0; i < n; i++) begin
            if (i == chg) u_if.tx_dat = new_dat;
            check(tag, {30'd0, u_if.tx_busy, u_if.txd},
                  {30'd0, 1'b1, frame_bit(d, ^d, 1'b1, i / DIV)});
            @(negedge clk_bus);
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic par, input logic stp);
        for (int b = 0; b < NB; b++) begin
            u_if.rxd = frame_bit(d, par, stp, b);
            repeat (DIV) @(negedge clk_bus);
        end
    endtask

    int r0, e0;

    initial begin
        u_if.tx_start = 1'b0;
        u_if.tx_dat   = 8'h00;
        u_if.rxd      = 1'b1;

        // ---- reset state
        repeat (3) @(negedge clk_bus);
        check("rst_txd",      {31'd0, u_if.txd},      32'd1);
        check("rst_tx_busy",  {31'd0, u_if.tx_busy},  32'd0);
        check("rst_rx_ready", {31'd0, u_if.rx_ready}, 32'd0);
        check("rst_rx_err",   {31'd0, u_if.rx_err},   32'd0);
        check("rst_rx_dat",   {24'd0, u_if.rx_dat},   32'd0);
        rst_bus = 1'b0;
        repeat (2) @(negedge clk_bus);

        // ---- T1: single byte 0x55, one-cycle request
        u_if.tx_start = 1'b1;
        u_if.tx_dat   = 8'h55;
        @(negedge clk_bus);
        u_if.tx_start = 1'b0;
        check_tx("t1_frame", 8'h55, NB * DIV, -1, 8'h00);
        check("t1_idle", {30'd0, u_if.tx_busy, u_if.txd}, 32'd1);
        repeat (3) @(negedge clk_bus);
        check("t1_still_idle", {30'd0, u_if.tx_busy, u_if.txd}, 32'd1);

        // ---- T2: receive 0xA3
        r0 = rdy_cnt; e0 = err_cnt;
        send_rx(8'hA3, ^8'hA3, 1'b1);
        repeat (8) @(negedge clk_bus);
        check("t2_ready_pulses", rdy_cnt - r0, 32'd1);
        check("t2_err_pulses",   err_cnt - e0, 32'd0);
        check("t2_rx_dat",       {24'd0, u_if.rx_dat}, 32'hA3);

        // ---- T3: 2-cycle start glitch
        r0 = rdy_cnt; e0 = err_cnt;
        u_if.rxd = 1'b0;
        repeat (2) @(negedge clk_bus);
        u_if.rxd = 1'b1;
        repeat (20) @(negedge clk_bus);
        check("t3_ready_pulses", rdy_cnt - r0, 32'd0);
        check("t3_err_pulses",   err_cnt - e0, 32'd0);

        // ---- T4: bad stop bit, line held low, then a good frame
        r0 = rdy_cnt; e0 = err_cnt;
        send_rx(8'h3C, ^8'h3C, 1'b0);
        repeat (40) @(negedge clk_bus);
        u_if.rxd = 1'b1;
        repeat (10) @(negedge clk_bus);
        check("t4_err_pulses",   err_cnt - e0, 32'd1);
        check("t4_ready_pulses", rdy_cnt - r0, 32'd0);
        check("t4_rx_dat_kept",  {24'd0, u_if.rx_dat}, 32'hA3);
        r0 = rdy_cnt; e0 = err_cnt;
        send_rx(8'h11, ^8'h11, 1'b1);
        repeat (8) @(negedge clk_bus);
        check("t4_good_ready", rdy_cnt - r0, 32'd1);
        check("t4_good_err",   err_cnt - e0, 32'd0);
        check("t4_good_dat",   {24'd0, u_if.rx_dat}, 32'h11);

        // ---- T5: held tx_start, back-to-back frames, reset abort
        u_if.tx_start = 1'b1;
        u_if.tx_dat   = 8'h01;
        @(negedge clk_bus);
        check_tx("t5_frame1", 8'h01, NB * DIV, 20, 8'h02);
        check("t5_gap", {30'd0, u_if.tx_busy, u_if.txd}, 32'd1);
        @(negedge clk_bus);
        check_tx("t5_frame2", 8'h02, 4 * DIV, -1, 8'h00);
        rst_bus       = 1'b1;
        u_if.tx_start = 1'b0;
        @(negedge clk_bus);
        check("t5_rst_abort", {30'd0, u_if.tx_busy, u_if.txd}, 32'd1);
        rst_bus = 1'b0;
        repeat (3) @(negedge clk_bus);
        check("t5_after_rst", {30'd0, u_if.tx_busy, u_if.txd}, 32'd1);

`ifdef UART_PARITY_EN
        // ---- T6: parity on TX and RX
        u_if.tx_start = 1'b1;
        u_if.tx_dat   = 8'h07;
        @(negedge clk_bus);
        u_if.tx_start = 1'b0;
        check_tx("t6_tx_frame", 8'h07, NB * DIV, -1, 8'h00);
        check("t6_tx_idle", {30'd0, u_if.tx_busy, u_if.txd}, 32'd1);
        r0 = rdy_cnt; e0 = err_cnt;
        send_rx(8'h07, 1'b0, 1'b1);
        repeat (8) @(negedge clk_bus);
        check("t6_par_err",   err_cnt - e0, 32'd1);
        check("t6_par_ready", rdy_cnt - r0, 32'd0);
        check("t6_par_dat",   {24'd0, u_if.rx_dat}, 32'h00);
`endif

        check("never_both_pulses", both_cnt, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
